// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit between the execute stage and a
// handshaked, bus-word-aligned memory port. One request per transaction;
// store data is lane-shifted with byte enables, load data is returned
// sign- or zero-extended.
// Build option: define LSU_MISALIGN_SPLIT_EN to split accesses that straddle
// a bus word into two beats. Without it, any access whose offset is not a
// multiple of its size is rejected with resp_err and no bus beat.
module lsu_ctrl #(
  parameter int XLEN  = 64,
  parameter int BYTES = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_load,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_data,
  output logic             resp_err,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [BYTES-1:0] mem_wmask,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata
);

  typedef enum logic [2:0] {IDLE, BEAT1, WAIT1, BEAT2, WAIT2, RESP} state_t;

  state_t           r_state;
  logic             r_load;
  logic [2:0]       r_f3;
  logic [OFF_W-1:0] r_off;

  logic [OFF_W-1:0] w_off;
  logic [XLEN-1:0]  w_addr_al;
  logic [3:0]       w_size;
  logic [7:0]       w_mask_base;
  logic             w_illegal;
  logic [XLEN-1:0]  w_beat1_data;
  logic [BYTES-1:0] w_beat1_mask;
  logic [XLEN-1:0]  w_raw;
  logic [XLEN-1:0]  w_left;
  logic [XLEN-1:0]  w_load_res;
  logic [7:0]       w_nbits;
  logic [7:0]       w_pad;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic             r_split;
  logic [XLEN-1:0]  r_addr_al;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_hi_wdata;
  logic [BYTES-1:0] r_hi_wmask;
  logic             w_split;
  logic [2*XLEN-1:0]  w_wide_data;
  logic [2*BYTES-1:0] w_wide_mask;
  logic [XLEN-1:0]  w_lo;
  logic [XLEN-1:0]  w_hi;
`endif

  assign w_off     = req_addr[OFF_W-1:0];
  assign w_addr_al = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};

  // Decode the incoming request: size, legality, split and beat-1 lane data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_size      = 4'd1 << req_funct3[1:0];
    w_mask_base = 8'h01;
    case (req_funct3[1:0])
      2'b00:   w_mask_base = 8'h01;
      2'b01:   w_mask_base = 8'h03;
      2'b10:   w_mask_base = 8'h0F;
      default: w_mask_base = 8'hFF;
    endcase
    w_illegal = 1'b0;
    if (!req_load && req_funct3[2])
      w_illegal = 1'b1;
    if (req_load && req_funct3 == 3'b111)
      w_illegal = 1'b1;
    if (XLEN == 32 && (req_funct3[1:0] == 2'b11 || (req_load && req_funct3 == 3'b110)))
      w_illegal = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
    w_split      = (5'(w_off) + 5'(w_size)) > 5'(BYTES);
    w_wide_data  = {{XLEN{1'b0}}, req_wdata} << {w_off, 3'b000};
    w_wide_mask  = (2*BYTES)'(w_mask_base) << w_off;
    w_beat1_data = w_wide_data[XLEN-1:0];
    w_beat1_mask = w_wide_mask[BYTES-1:0];
`else
    if ((5'(w_off) & 5'(w_size - 4'd1)) != 5'd0)
      w_illegal = 1'b1;
    w_beat1_data = req_wdata << {w_off, 3'b000};
    w_beat1_mask = BYTES'(w_mask_base) << w_off;
`endif
  end

  // Align the returned word(s) to the request offset and extend to XLEN.
  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    w_lo  = (r_state == WAIT1) ? mem_rdata : r_lo;
    w_hi  = (r_state == WAIT2) ? mem_rdata : {XLEN{1'b0}};
    w_raw = XLEN'({w_hi, w_lo} >> {r_off, 3'b000});
`else
    w_raw = mem_rdata >> {r_off, 3'b000};
`endif
    w_nbits    = 8'd8 << r_f3[1:0];
    w_pad      = (w_nbits >= 8'(XLEN)) ? 8'd0 : 8'(XLEN) - w_nbits;
    w_left     = w_raw << w_pad;
    w_load_res = r_f3[2] ? (w_left >> w_pad) : XLEN'($signed(w_left) >>> w_pad);
  end

  // Transaction FSM with registered handshake, bus and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_load     <= 1'b0;
      r_f3       <= 3'b000;
      r_off      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split    <= 1'b0;
      r_addr_al  <= '0;
      r_lo       <= '0;
      r_hi_wdata <= '0;
      r_hi_wmask <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
      resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_load    <= req_load;
            r_f3      <= req_funct3;
            r_off     <= w_off;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split    <= w_split;
            r_addr_al  <= w_addr_al;
            r_hi_wdata <= req_load ? '0 : w_wide_data[2*XLEN-1:XLEN];
            r_hi_wmask <= req_load ? '0 : w_wide_mask[2*BYTES-1:BYTES];
`endif
            if (w_illegal) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              r_state   <= BEAT1;
              mem_valid <= 1'b1;
              mem_we    <= !req_load;
              mem_addr  <= w_addr_al;
              mem_wdata <= req_load ? '0 : w_beat1_data;
              mem_wmask <= req_load ? '0 : w_beat1_mask;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (!r_load && r_split) begin
              r_state   <= BEAT2;
              mem_addr  <= r_addr_al + XLEN'(BYTES);
              mem_wdata <= r_hi_wdata;
              mem_wmask <= r_hi_wmask;
            end else
`endif
            begin
              mem_valid <= 1'b0;
              mem_we    <= 1'b0;
              mem_wmask <= '0;
              if (r_load) begin
                r_state <= WAIT1;
              end else begin
                r_state    <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_data  <= '0;
              end
            end
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (r_split) begin
              r_lo      <= mem_rdata;
              r_state   <= BEAT2;
              mem_valid <= 1'b1;
              mem_addr  <= r_addr_al + XLEN'(BYTES);
            end else
`endif
            begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= w_load_res;
            end
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        BEAT2: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= '0;
            if (r_load) begin
              r_state <= WAIT2;
            end else begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= '0;
            end
          end
        end
        WAIT2: begin
          if (mem_rvalid) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= w_load_res;
          end
        end
`endif
        RESP: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
